// File: rtl/branch_target_lut.sv
// Fully associative branch target buffer with saturating direction counters; lookup is combinational, update lands on the next edge.
// No backpressure: every update strobe is accepted, and flush wins over a coincident update.
module branch_target_lut #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] read_key,
    output logic [ADDR_WIDTH-1:0] read_val,
    output logic                  read_valid,
    output logic                  read_taken,
    input  logic                  update,
    input  logic [ADDR_WIDTH-1:0] update_key,
    input  logic [ADDR_WIDTH-1:0] update_val,
    input  logic                  update_taken
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [ADDR_WIDTH-1:0] key_q [DEPTH];
    logic [ADDR_WIDTH-1:0] key_d [DEPTH];
    logic [ADDR_WIDTH-1:0] val_q [DEPTH];
    logic [ADDR_WIDTH-1:0] val_d [DEPTH];
    logic [CTR_BITS-1:0]   ctr_q [DEPTH];
    logic [CTR_BITS-1:0]   ctr_d [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      ptr_d;

    logic                  rd_hit;
    logic [PTR_W-1:0]      rd_idx;
    logic                  upd_hit;
    logic [PTR_W-1:0]      upd_idx;
    logic                  has_free;
    logic [PTR_W-1:0]      free_idx;
    logic [PTR_W-1:0]      victim;

    // Descending scans so the lowest matching / free index is the one left standing.
    always_comb begin
        rd_hit   = 1'b0;
        rd_idx   = '0;
        upd_hit  = 1'b0;
        upd_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (key_q[i] == read_key)) begin
                rd_hit = 1'b1;
                rd_idx = PTR_W'(i);
            end
            if (valid_q[i] && (key_q[i] == update_key)) begin
                upd_hit = 1'b1;
                upd_idx = PTR_W'(i);
            end
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        read_valid = rd_hit;
        read_val   = rd_hit ? val_q[rd_idx] : '0;
        read_taken = rd_hit & ctr_q[rd_idx][CTR_BITS-1];
    end

    always_comb begin
        key_d   = key_q;
        val_d   = val_q;
        ctr_d   = ctr_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        victim  = has_free ? free_idx : ptr_q;
        if (flush) begin
            valid_d = '0;
            ptr_d   = '0;
        end else if (update) begin
            if (upd_hit) begin
                if (update_taken) begin
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_BITS'(1);
                    end
                    val_d[upd_idx] = update_val;
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_BITS'(1);
                end
            end else if (update_taken) begin
                key_d[victim]   = update_key;
                val_d[victim]   = update_val;
                ctr_d[victim]   = CTR_WEAK;
                valid_d[victim] = 1'b1;
                // Round-robin pointer only moves when it actually chose the victim.
                if (!has_free) begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
                ctr_q[i] <= '0;
            end
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            key_q   <= key_d;
            val_q   <= val_d;
            ctr_q   <= ctr_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_branch_target_lut.sv
// Directed bench for branch_target_lut at default parameters (16-bit, 8 entries, 2-bit counters).
module tb_branch_target_lut;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [15:0] read_key;
    logic [15:0] read_val;
    logic        read_valid;
    logic        read_taken;
    logic        update;
    logic [15:0] update_key;
    logic [15:0] update_val;
    logic        update_taken;

    int vectors = 0;
    int errors  = 0;

    branch_target_lut dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .read_key     (read_key),
        .read_val     (read_val),
        .read_valid   (read_valid),
        .read_taken   (read_taken),
        .update       (update),
        .update_key   (update_key),
        .update_val   (update_val),
        .update_taken (update_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [15:0] val, input logic tk);
        chk({tag, ".valid"}, {15'd0, read_valid}, {15'd0, vld});
        chk({tag, ".val"},   read_val,            val);
        chk({tag, ".taken"}, {15'd0, read_taken}, {15'd0, tk});
    endtask

    task automatic look(input string tag, input logic [15:0] k, input logic vld,
                        input logic [15:0] val, input logic tk);
        @(negedge clk);
        read_key = k;
        #1;
        chk_out(tag, vld, val, tk);
    endtask

    task automatic upd(input logic [15:0] k, input logic [15:0] v, input logic tk);
        @(negedge clk);
        update       = 1'b1;
        update_key   = k;
        update_val   = v;
        update_taken = tk;
        @(posedge clk);
        #1;
        update = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        flush        = 1'b0;
        read_key     = 16'h0000;
        update       = 1'b0;
        update_key   = 16'h0000;
        update_val   = 16'h0000;
        update_taken = 1'b0;

        #2;
        chk_out("reset_held", 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        look("reset_released", 16'h0000, 1'b0, 16'h0000, 1'b0);

        // First allocation lands weakly taken (ctr=2).
        upd(16'h0040, 16'h0100, 1'b1);
        look("alloc_0040", 16'h0040, 1'b1, 16'h0100, 1'b1);

        upd(16'h0040, 16'h0bad, 1'b0);
        look("nt1_ctr1", 16'h0040, 1'b1, 16'h0100, 1'b0);
        upd(16'h0040, 16'h0bad, 1'b0);
        look("nt2_ctr0", 16'h0040, 1'b1, 16'h0100, 1'b0);
        upd(16'h0040, 16'h0bad, 1'b0);
        look("nt3_sat0", 16'h0040, 1'b1, 16'h0100, 1'b0);

        upd(16'h0040, 16'h0111, 1'b1);
        look("t1_ctr1", 16'h0040, 1'b1, 16'h0111, 1'b0);
        upd(16'h0040, 16'h0122, 1'b1);
        look("t2_ctr2", 16'h0040, 1'b1, 16'h0122, 1'b1);
        upd(16'h0040, 16'h0133, 1'b1);
        look("t3_ctr3", 16'h0040, 1'b1, 16'h0133, 1'b1);
        upd(16'h0040, 16'h0144, 1'b1);
        look("t4_sat3", 16'h0040, 1'b1, 16'h0144, 1'b1);
        // From a saturated 3 one not-taken gives 2 (still taken); a wrap to 0 would not.
        upd(16'h0040, 16'h0bad, 1'b0);
        look("sat3_then_nt", 16'h0040, 1'b1, 16'h0144, 1'b1);

        do_flush();
        look("flush_clears", 16'h0040, 1'b0, 16'h0000, 1'b0);

        for (int k = 1; k <= 8; k++) begin
            upd(16'(k * 16), 16'(16'h1000 + k * 16), 1'b1);
        end
        look("fill_0010", 16'h0010, 1'b1, 16'h1010, 1'b1);
        look("fill_0080", 16'h0080, 1'b1, 16'h1080, 1'b1);

        upd(16'h0090, 16'h1090, 1'b1);
        look("evict0_0010", 16'h0010, 1'b0, 16'h0000, 1'b0);
        look("evict0_0090", 16'h0090, 1'b1, 16'h1090, 1'b1);
        look("evict0_0020", 16'h0020, 1'b1, 16'h1020, 1'b1);
        upd(16'h00a0, 16'h10a0, 1'b1);
        look("evict1_0020", 16'h0020, 1'b0, 16'h0000, 1'b0);
        look("evict1_0030", 16'h0030, 1'b1, 16'h1030, 1'b1);
        look("evict1_00a0", 16'h00a0, 1'b1, 16'h10a0, 1'b1);

        // Read and update of the same key in one cycle: no bypass.
        @(negedge clk);
        read_key     = 16'h0200;
        update       = 1'b1;
        update_key   = 16'h0200;
        update_val   = 16'h1200;
        update_taken = 1'b1;
        #1;
        chk_out("same_cycle_pre", 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        update = 1'b0;
        chk_out("same_cycle_post", 1'b1, 16'h1200, 1'b1);

        // Update and flush on one edge: flush wins, pointer back to 0.
        @(negedge clk);
        update       = 1'b1;
        update_key   = 16'h0210;
        update_val   = 16'h1210;
        update_taken = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        update = 1'b0;
        flush  = 1'b0;
        look("uflush_0210", 16'h0210, 1'b0, 16'h0000, 1'b0);
        look("uflush_0200", 16'h0200, 1'b0, 16'h0000, 1'b0);
        look("uflush_0090", 16'h0090, 1'b0, 16'h0000, 1'b0);

        for (int k = 0; k < 8; k++) begin
            upd(16'(16'h0400 + k * 16), 16'(16'h2400 + k * 16), 1'b1);
        end
        upd(16'h0480, 16'h2480, 1'b1);
        look("ptr0_0400", 16'h0400, 1'b0, 16'h0000, 1'b0);
        look("ptr0_0430", 16'h0430, 1'b1, 16'h2430, 1'b1);
        look("ptr0_0480", 16'h0480, 1'b1, 16'h2480, 1'b1);

        // Not-taken miss must not allocate (would otherwise evict entry 1, key 0x0410).
        upd(16'h0300, 16'h2300, 1'b0);
        look("nt_miss_0300", 16'h0300, 1'b0, 16'h0000, 1'b0);
        look("nt_miss_0410", 16'h0410, 1'b1, 16'h2410, 1'b1);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        look("after_reset_0480", 16'h0480, 1'b0, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
